// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register pending latency, exception drain/hold FSM, stall cause.
// Optional stall-cycle counter built when HAZ_PERF_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int RADDR_WIDTH = 5,
    parameter int ALU_LAT     = 1,
    parameter int LOAD_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [RADDR_WIDTH-1:0] id_rs1,
    input  logic                   id_read1,
    input  logic [RADDR_WIDTH-1:0] id_rs2,
    input  logic                   id_read2,
    input  logic                   id_early_use,
    input  logic                   id_reg_write,
    input  logic [RADDR_WIDTH-1:0] id_rd,
    input  logic                   id_mem_read,
    input  logic                   env_exception,
    input  logic                   bp_exception,
    input  logic                   exc_resume,
    output logic                   stall,
    output logic [1:0]             stall_cause,
    output logic                   exc_drained,
    output logic [31:0]            perf_stall_cnt
);
    localparam int NREG = 1 << RADDR_WIDTH;
    localparam int CW   = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CW-1:0] ALU_L  = CW'(ALU_LAT);
    localparam logic [CW-1:0] LOAD_L = CW'(LOAD_LAT);

    // x0 has no storage; lookups of address 0 return zero
    logic [CW-1:0] p_q [1:NREG-1];
    logic [CW-1:0] p_d [1:NREG-1];
    logic [1:0]    state_q, state_d;

    logic [CW-1:0] p_rs1, p_rs2;
    logic          rd1, rd2;
    logic          early_haz, data_haz, exc_stall;
    logic          issue, all_zero;

    always_comb begin
        p_rs1 = '0;
        p_rs2 = '0;
        if (id_rs1 != '0) p_rs1 = p_q[id_rs1];
        if (id_rs2 != '0) p_rs2 = p_q[id_rs2];
    end

    assign rd1 = id_valid & id_read1 & (id_rs1 != '0);
    assign rd2 = id_valid & id_read2 & (id_rs2 != '0);

    // EX->EX forwarding covers a producer one cycle from done, but ID consumers cannot use it
    assign early_haz = id_early_use &
                       ((rd1 & (p_rs1 != '0)) | (rd2 & (p_rs2 != '0)));
    assign data_haz  = ~id_early_use &
                       ((rd1 & (p_rs1 > CW'(1))) | (rd2 & (p_rs2 > CW'(1))));

    assign exc_stall = (state_q != ST_IDLE) | env_exception | bp_exception;

    assign stall = exc_stall | early_haz | data_haz;

    always_comb begin
        stall_cause = 2'b00;
        if (exc_stall)      stall_cause = 2'b11;
        else if (early_haz) stall_cause = 2'b10;
        else if (data_haz)  stall_cause = 2'b01;
    end

    assign exc_drained = (state_q == ST_HOLD);

    assign issue = id_valid & ~stall & id_reg_write & (id_rd != '0);

    always_comb begin
        all_zero = 1'b1;
        for (int r = 1; r < NREG; r++) begin
            p_d[r] = (p_q[r] != '0) ? p_q[r] - CW'(1) : '0;
            if (issue && (id_rd == RADDR_WIDTH'(r)))
                p_d[r] = id_mem_read ? LOAD_L : ALU_L;
            if (p_q[r] != '0) all_zero = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (env_exception | bp_exception) state_d = ST_DRAIN;
            ST_DRAIN: if (all_zero)                     state_d = ST_HOLD;
            ST_HOLD:  if (exc_resume)                   state_d = ST_IDLE;
            default:                                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int r = 1; r < NREG; r++) p_q[r] <= '0;
        end else begin
            state_q <= state_d;
            for (int r = 1; r < NREG; r++) p_q[r] <= p_d[r];
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_q <= '0;
        else if (stall && (perf_q != 32'hFFFF_FFFF))
            perf_q <= perf_q + 32'd1;
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
